// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM data-port arbiter.
//   owner_e  : identifies which requester owns an access/response
//   resp_t   : one-deep response record carried from gnt cycle to rvalid cycle
//   SRAM_BASE_ADDR_DEFAULT : byte base of the SRAM window
package sram_arb_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_FAB  = 1'b1
  } owner_e;

  localparam logic [31:0] SRAM_BASE_ADDR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
    logic   is_read;
  } resp_t;

  // Empty response record (no response pending).
  function automatic resp_t resp_idle();
    resp_t r;
    r.valid   = 1'b0;
    r.owner   = OWNER_CORE;
    r.err     = 1'b0;
    r.is_read = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a last-owner register.
//   clk, resetn : clock, synchronous active-low reset
//   req_i[0]    : core eligible, req_i[1] : fabric eligible
//   gnt_o       : one-hot (or zero) grant vector, same cycle as req_i
// On a tie the requester that did not win last time is granted. After reset
// the fabric is recorded as last owner, so the core wins the first tie.
module rr_arbiter2 import sram_arb_pkg::*; (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  owner_e last_owner_q;
  owner_e last_owner_d;

  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_owner_q == OWNER_CORE) ? 2'b10 : 2'b01;
      default: gnt_o = '0;
    endcase
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (gnt_o[0]) begin
      last_owner_d = OWNER_CORE;
    end else if (gnt_o[1]) begin
      last_owner_d = OWNER_FAB;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_owner_q <= OWNER_FAB;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/sram_data_arbiter.sv
// Arbitrates the Ibex data port and a fabric-side master onto the single RW
// port of the sram_1rw1r_32_256_8_sky130 data macro.
//   clk, resetn            : clock, synchronous active-low reset
//   core_* / fab_*         : OBI-style req/gnt/rvalid ports of the two masters
//   fab_en_i               : 0 masks the fabric requester completely
//   sram_*0_o / sram_dout0_i : macro port 0 (active-low csb/web, 1-cycle read)
//   conflict_cnt_o         : saturating count of cycles with both eligible
// Out-of-window accesses are granted but never reach the macro; they return
// rvalid with err=1 and rdata=0. Every grant, read or write, is answered
// with exactly one rvalid in the following cycle.
module sram_data_arbiter import sram_arb_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = SRAM_BASE_ADDR_DEFAULT,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  core_req_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic                  core_err_o,
  input  logic                  core_we_i,
  input  logic [3:0]            core_be_i,
  input  logic [31:0]           core_addr_i,
  input  logic [31:0]           core_wdata_i,
  output logic [31:0]           core_rdata_o,

  input  logic                  fab_req_i,
  output logic                  fab_gnt_o,
  output logic                  fab_rvalid_o,
  output logic                  fab_err_o,
  input  logic                  fab_we_i,
  input  logic [3:0]            fab_be_i,
  input  logic [31:0]           fab_addr_i,
  input  logic [31:0]           fab_wdata_i,
  output logic [31:0]           fab_rdata_o,
  input  logic                  fab_en_i,

  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [3:0]            sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [31:0]           sram_din0_o,
  input  logic [31:0]           sram_dout0_i,

  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  // Eligibility is gated by resetn so nothing is granted while reset is held.
  logic       core_elig;
  logic       fab_elig;
  logic [1:0] gnt;
  logic       any_gnt;

  always_comb begin
    core_elig = resetn & core_req_i;
    fab_elig  = resetn & fab_req_i & fab_en_i;
  end

  rr_arbiter2 u_rr_arbiter2 (
    .clk    (clk),
    .resetn (resetn),
    .req_i  ({fab_elig, core_elig}),
    .gnt_o  (gnt)
  );

  always_comb begin
    core_gnt_o = gnt[0];
    fab_gnt_o  = gnt[1];
    any_gnt    = |gnt;
  end

  // Winner's request fields.
  logic                  win_we;
  logic [3:0]            win_be;
  logic [31:0]           win_addr;
  logic [31:0]           win_wdata;
  logic                  win_in_range;
  logic [ADDR_WIDTH-1:0] win_word;
  logic                  unused_addr_lsbs;

  always_comb begin
    win_we    = gnt[1] ? fab_we_i    : core_we_i;
    win_be    = gnt[1] ? fab_be_i    : core_be_i;
    win_addr  = gnt[1] ? fab_addr_i  : core_addr_i;
    win_wdata = gnt[1] ? fab_wdata_i : core_wdata_i;
    win_in_range = (win_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    win_word     = win_addr[ADDR_WIDTH+1:2];
    // Byte offset within the word is not used by a word-wide macro.
    unused_addr_lsbs = ^win_addr[1:0];
  end

  // Address, data and mask are presented combinationally in the grant cycle
  // and otherwise held from the last grant so the macro pins do not toggle.
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic [3:0]            wmask_q, wmask_d;

  always_comb begin
    addr_d  = addr_q;
    din_d   = din_q;
    wmask_d = wmask_q;
    if (any_gnt) begin
      addr_d  = win_word;
      din_d   = win_wdata;
      wmask_d = win_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q  <= '0;
      din_q   <= '0;
      wmask_q <= '0;
    end else begin
      addr_q  <= addr_d;
      din_q   <= din_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    sram_csb0_o   = ~(any_gnt & win_in_range);
    sram_web0_o   = (any_gnt & win_in_range) ? ~win_we : 1'b1;
    sram_addr0_o  = addr_d;
    sram_din0_o   = din_d;
    sram_wmask0_o = wmask_d;
  end

  // Response pipeline: one record, loaded on every grant.
  resp_t resp_q, resp_d;

  always_comb begin
    resp_d = resp_idle();
    if (any_gnt) begin
      resp_d.valid   = 1'b1;
      resp_d.owner   = gnt[1] ? OWNER_FAB : OWNER_CORE;
      resp_d.err     = ~win_in_range;
      resp_d.is_read = ~win_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_q <= resp_idle();
    end else begin
      resp_q <= resp_d;
    end
  end

  // The response outputs are also qualified by resetn: a response pending when
  // reset is asserted must not surface during the reset cycle itself.
  logic        resp_live;
  logic [31:0] resp_rdata;

  always_comb begin
    resp_live  = resp_q.valid & resetn;
    resp_rdata = (resp_live & resp_q.is_read & ~resp_q.err) ? sram_dout0_i : '0;

    core_rvalid_o = resp_live & (resp_q.owner == OWNER_CORE);
    fab_rvalid_o  = resp_live & (resp_q.owner == OWNER_FAB);
    core_err_o    = core_rvalid_o & resp_q.err;
    fab_err_o     = fab_rvalid_o  & resp_q.err;
    core_rdata_o  = core_rvalid_o ? resp_rdata : '0;
    fab_rdata_o   = fab_rvalid_o  ? resp_rdata : '0;
  end

  // Saturating conflict counter.
  logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (core_elig && fab_elig && !(&conflict_cnt_q)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  always_comb begin
    conflict_cnt_o = conflict_cnt_q;
  end

endmodule
